// File: rtl/spi_flash_resp_if.sv
// ----------------------------------------------------------------------------
// spi_flash_resp_if : SPI pin bundle, controller = master, flash = slave. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface spi_flash_resp_if;
  logic CLK;
  logic CS;
  logic D;
  logic Q;

  modport master (output CLK, output CS, output D, input Q);
  modport slave  (input CLK, input CS, input D, output Q);
endinterface

`default_nettype wire

// File: rtl/spi_flash_resp.sv
// ----------------------------------------------------------------------------
// spi_flash_resp : oversampled SPI-flash responder (READ/WREN/PP/SE/RDSR). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_flash_resp #(
  parameter int ADDR_W      = 8,
  parameter int SECTOR_W    = 6,
  parameter int BUSY_CYCLES = 200
) (
  input  logic            clk,
  input  logic            reset,
  spi_flash_resp_if.slave spi,
  output logic            wip,
  output logic            wel
);
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int BUSY_MAX = (BUSY_CYCLES > DEPTH) ? BUSY_CYCLES : DEPTH;
  localparam int BW       = $clog2(BUSY_MAX + 1);
  localparam int EW       = ADDR_W + 1;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CMD    = 4'd1;
  localparam logic [3:0] ST_ADDR   = 4'd2;
  localparam logic [3:0] ST_RD     = 4'd3;
  localparam logic [3:0] ST_PP     = 4'd4;
  localparam logic [3:0] ST_SE     = 4'd5;
  localparam logic [3:0] ST_WREN   = 4'd6;
  localparam logic [3:0] ST_STATUS = 4'd7;
  localparam logic [3:0] ST_IGNORE = 4'd8;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'hD8;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  logic [2:0]        clk_sync_q, cs_sync_q;
  logic [1:0]        d_sync_q;
  logic [3:0]        state_q, state_d;
  logic [6:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [5:0]        bits_q;
  logic [1:0]        addr_cnt_q;
  logic [7:0]        op_q;
  logic [ADDR_W-1:0] addr_q, addr_in, page_next, erase_ptr_q;
  logic [EW-1:0]     erase_cnt_q;
  logic [BW-1:0]     busy_q;
  logic [7:0]        tx_q, tx_src, rx_byte;
  logic              q_q, wel_q, pp_wrote_q;
  logic [7:0]        mem_q [DEPTH];

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, byte_done, addr_done;
  logic in_tx, commit_wren, commit_pp, commit_se, tx_load, pp_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '0;
      cs_sync_q  <= '0;
      d_sync_q   <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], spi.CLK};
      cs_sync_q  <= {cs_sync_q[1:0], spi.CS};
      d_sync_q   <= {d_sync_q[0], spi.D};
    end
  end

  assign sclk_rise = (clk_sync_q[2:1] == 2'b01);
  assign sclk_fall = (clk_sync_q[2:1] == 2'b10);
  assign cs_rise   = (cs_sync_q[2:1] == 2'b01);
  assign cs_fall   = (cs_sync_q[2:1] == 2'b10);
  assign rx_byte   = {shift_q, d_sync_q[1]};
  assign addr_in   = ADDR_W'({addr_q, rx_byte});
  assign byte_done = sclk_rise && !cs_rise && !cs_fall && (state_q != ST_IDLE) && (bit_cnt_q == 3'd7);
  assign addr_done = byte_done && (state_q == ST_ADDR) && (addr_cnt_q == 2'd2);
  assign wip       = (busy_q != '0);
  assign wel       = wel_q;
  assign spi.Q     = q_q;

  // Page program wraps within the 256-byte page; narrower arrays just wrap whole.
  generate
    if (ADDR_W > 8) begin : g_page
      assign page_next = {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};
    end else begin : g_flat
      assign page_next = addr_q + ADDR_W'(1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else if (cs_fall) begin
      state_d = ST_CMD;
    end else if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          if (wip && rx_byte != OP_RDSR) state_d = ST_IGNORE;
          else begin
            case (rx_byte)
              OP_READ, OP_PP, OP_SE: state_d = ST_ADDR;
              OP_RDSR:               state_d = ST_STATUS;
              OP_WREN:               state_d = ST_WREN;
              default:               state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (addr_cnt_q == 2'd2) begin
            if (op_q == OP_READ)    state_d = ST_RD;
            else if (op_q == OP_PP) state_d = ST_PP;
            else                    state_d = ST_SE;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    in_tx       = (state_q == ST_RD) || (state_q == ST_STATUS);
    commit_wren = cs_rise && (state_q == ST_WREN) && (bits_q == 6'd8);
    commit_pp   = cs_rise && (state_q == ST_PP) && wel_q && pp_wrote_q;
    commit_se   = cs_rise && (state_q == ST_SE) && wel_q && (bits_q == 6'd32);
    pp_we       = byte_done && (state_q == ST_PP) && wel_q;
    tx_load     = byte_done && (in_tx || state_d == ST_STATUS || state_d == ST_RD);
    if (state_q == ST_CMD || state_q == ST_STATUS) tx_src = {6'b0, wel_q, wip};
    else if (state_q == ST_ADDR)                   tx_src = mem_q[addr_in];
    else                                           tx_src = mem_q[addr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      bits_q      <= '0;
      addr_cnt_q  <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      q_q         <= 1'b0;
      wel_q       <= 1'b0;
      pp_wrote_q  <= 1'b0;
      busy_q      <= BW'(DEPTH);
      erase_ptr_q <= '0;
      erase_cnt_q <= EW'(DEPTH);
    end else begin
      if (busy_q != '0) busy_q <= busy_q - BW'(1);
      if (erase_cnt_q != '0) begin
        erase_cnt_q <= erase_cnt_q - EW'(1);
        erase_ptr_q <= erase_ptr_q + ADDR_W'(1);
      end
      if (cs_fall) begin
        bit_cnt_q  <= '0;
        bits_q     <= '0;
        addr_cnt_q <= '0;
        pp_wrote_q <= 1'b0;
      end else if (sclk_rise && state_q != ST_IDLE) begin
        shift_q   <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bits_q != 6'h3F) bits_q <= bits_q + 6'd1;
      end
      if (byte_done) begin
        case (state_q)
          ST_CMD:  op_q <= rx_byte;
          ST_ADDR: begin
            addr_cnt_q <= addr_cnt_q + 2'd1;
            // READ pre-fetches the first byte here, so the pointer moves past it.
            addr_q <= (addr_done && op_q == OP_READ) ? addr_in + ADDR_W'(1) : addr_in;
          end
          ST_RD:   addr_q <= addr_q + ADDR_W'(1);
          ST_PP: begin
            addr_q <= page_next;
            if (wel_q) pp_wrote_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (tx_load) begin
        tx_q <= tx_src;
      end else if (sclk_fall && in_tx) begin
        q_q  <= tx_q[7];
        tx_q <= {tx_q[6:0], 1'b0};
      end
      if (!in_tx) q_q <= 1'b0;
      if (commit_wren) wel_q <= 1'b1;
      if (commit_pp || commit_se) begin
        wel_q  <= 1'b0;
        busy_q <= BW'(BUSY_CYCLES);
      end
      if (commit_se) begin
        erase_ptr_q <= addr_q & ~ADDR_W'(2 ** SECTOR_W - 1);
        erase_cnt_q <= EW'(2 ** SECTOR_W);
      end
    end
  end

  // Erase and program never overlap: programming needs wip low, erasing keeps it high.
  always_ff @(posedge clk) begin
    if (erase_cnt_q != '0) mem_q[erase_ptr_q] <= 8'hFF;
    else if (pp_we)        mem_q[addr_q]      <= rx_byte;
  end
endmodule

`default_nettype wire

// File: tb/tb_spi_flash_resp.sv
// ----------------------------------------------------------------------------
// tb_spi_flash_resp : self-checking bench for spi_flash_resp. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_flash_resp;
  localparam int DEPTH = 256;
  localparam int BUSY  = 200;
  localparam int H     = 6;

  logic clk, reset, wip, wel;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] model [DEPTH];
  bit         wel_m;
  logic [7:0] wbuf [64];
  logic [7:0] rbuf [64];

  spi_flash_resp_if bus ();

  spi_flash_resp #(.ADDR_W(8), .SECTOR_W(6), .BUSY_CYCLES(BUSY)) dut (
    .clk   (clk),
    .reset (reset),
    .spi   (bus),
    .wip   (wip),
    .wel   (wel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.D = tx[7-i];
      repeat (H) @(negedge clk);
      rx[7-i] = bus.Q;
      bus.CLK = 1'b1;
      repeat (H) @(negedge clk);
      bus.CLK = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.CS = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (2) @(negedge clk);
    bus.CS = 1'b1;
    bus.D  = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] r;
    spi_bits(a[23:16], 8, r);
    spi_bits(a[15:8], 8, r);
    spi_bits(a[7:0], 8, r);
  endtask

  task automatic wren();
    logic [7:0] r;
    cs_low();
    spi_bits(8'h06, 8, r);
    cs_high();
    wel_m = 1'b1;
  endtask

  task automatic rdsr(output logic [7:0] s);
    logic [7:0] r;
    cs_low();
    spi_bits(8'h05, 8, r);
    spi_bits(8'h00, 8, s);
    cs_high();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] r;
    cs_low();
    spi_bits(8'h03, 8, r);
    send_addr(a);
    for (int i = 0; i < n; i++) spi_bits(8'h00, 8, rbuf[i]);
    cs_high();
  endtask

  // Model: bytes land in the page at (page base + offset mod 256), then mod array depth.
  task automatic do_pp(input logic [23:0] a, input int n);
    logic [7:0] r;
    int idx;
    cs_low();
    spi_bits(8'h02, 8, r);
    send_addr(a);
    for (int i = 0; i < n; i++) spi_bits(wbuf[i], 8, r);
    cs_high();
    if (wel_m && n > 0) begin
      for (int i = 0; i < n; i++) begin
        idx = ((int'(a) & 32'hFFFF00) | ((int'(a) + i) & 32'hFF)) % DEPTH;
        model[idx] = wbuf[i];
      end
      wel_m = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (wip !== 1'b0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 5000) begin
      failures++;
      $display("FAIL wait_idle: wip still %b after %0d cycles, required 0", wip, g);
    end
  endtask

  task automatic check_read(input string name, input logic [23:0] a, input int n);
    logic [7:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = model[(int'(a) + i) % DEPTH];
      checks++;
      if (rbuf[i] !== exp) begin
        failures++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, rbuf[i], exp);
      end
    end
  endtask

  task automatic test_reset();
    int cnt = 0;
    logic [7:0] s;
    reset = 1'b1; bus.CS = 1'b1; bus.CLK = 1'b0; bus.D = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'hFF;
    wel_m = 1'b0;
    checks++;
    if (bus.Q !== 1'b0 || wel !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got Q=%b wel=%b expected Q=0 wel=0", bus.Q, wel);
    end
    while (wip === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != DEPTH) begin
      failures++;
      $display("FAIL reset_wip_cycles: got %0d expected %0d", cnt, DEPTH);
    end
    do_read(24'h000010, 4);
    check_read("reset_read", 24'h000010, 4);
    rdsr(s);
    checks++;
    if (s !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdsr: got %h expected 00", s);
    end
  endtask

  task automatic test_wren_pp();
    logic [7:0] s, r;
    int n01 = 0;
    wren();
    rdsr(s);
    checks++;
    if (s !== {6'b0, wel_m, 1'b0}) begin
      failures++;
      $display("FAIL wren_rdsr: got %h expected %h", s, {6'b0, wel_m, 1'b0});
    end
    wbuf[0] = 8'hAA; wbuf[1] = 8'h55; wbuf[2] = 8'h12; wbuf[3] = 8'h34;
    do_pp(24'h000020, 4);
    s = 8'hFF;
    cs_low();
    spi_bits(8'h05, 8, r);
    for (int k = 0; k < 20; k++) begin
      spi_bits(8'h00, 8, s);
      if (s == 8'h00) break;
      n01++;
      checks++;
      if (s !== 8'h01) begin
        failures++;
        $display("FAIL pp_poll_busy: got %h expected 01", s);
      end
    end
    cs_high();
    checks++;
    if (s !== 8'h00 || n01 == 0) begin
      failures++;
      $display("FAIL pp_poll_done: got final %h after %0d busy reads, expected 00 after >=1", s, n01);
    end
    checks++;
    if (wel !== wel_m) begin
      failures++;
      $display("FAIL pp_wel: got %b expected %b", wel, wel_m);
    end
    do_read(24'h000020, 4);
    check_read("pp_read", 24'h000020, 4);
  endtask

  task automatic test_pp_no_wren();
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    do_pp(24'h000030, 4);
    checks++;
    if (wel !== 1'b0 || wip !== 1'b0) begin
      failures++;
      $display("FAIL nowren_status: got wel=%b wip=%b expected 0 0", wel, wip);
    end
    do_read(24'h000030, 4);
    check_read("nowren_read", 24'h000030, 4);
  endtask

  task automatic test_page_wrap();
    wren();
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
    do_pp(24'h0000FE, 4);
    wait_idle();
    do_read(24'h0000FE, 4);
    check_read("wrap_read", 24'h0000FE, 4);
  endtask

  task automatic test_random();
    logic [23:0] a, r;
    int n, len;
    for (int it = 0; it < 6; it++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 3) != 0) wren();
      do_pp(a, n);
      wait_idle();
      r = (it % 2 == 0) ? a : 24'($urandom);
      len = $urandom_range(1, 6);
      do_read(r, len);
      check_read("rand_read", r, len);
    end
  endtask

  task automatic test_se();
    logic [7:0] r;
    int cnt = 0;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 254));
    wren();
    do_pp(24'h00003C, 8);
    wait_idle();
    wren();
    cs_low();
    spi_bits(8'hD8, 8, r);
    send_addr(24'h000025);
    for (int i = 0; i < 64; i++) model[i] = 8'hFF;
    wel_m = 1'b0;
    fork
      begin
        cs_high();
        do_read(24'h000040, 4);
      end
      begin
        int guard = 0;
        while (wip !== 1'b1 && guard < 50) begin
          @(negedge clk);
          guard++;
        end
        while (wip === 1'b1 && cnt < 1000) begin
          cnt++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (cnt != BUSY) begin
      failures++;
      $display("FAIL se_wip_cycles: got %0d expected %0d", cnt, BUSY);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== 8'h00) begin
        failures++;
        $display("FAIL busy_read_q[%0d]: got %h expected 00", i, rbuf[i]);
      end
    end
    checks++;
    if (wel !== 1'b0) begin
      failures++;
      $display("FAIL se_wel: got %b expected 0", wel);
    end
    wait_idle();
    do_read(24'h000020, 40);
    check_read("se_read", 24'h000020, 40);
  endtask

  task automatic test_wren_partial();
    logic [7:0] r, s;
    cs_low();
    spi_bits(8'h06, 5, r);
    cs_high();
    checks++;
    if (wel !== 1'b0) begin
      failures++;
      $display("FAIL partial_wren_wel: got %b expected 0", wel);
    end
    rdsr(s);
    checks++;
    if (s !== 8'h00) begin
      failures++;
      $display("FAIL partial_wren_rdsr: got %h expected 00", s);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] r, s;
    wren();
    checks++;
    if (wel !== wel_m) begin
      failures++;
      $display("FAIL midrst_wel_before: got %b expected %b", wel, wel_m);
    end
    cs_low();
    spi_bits(8'h03, 8, r);
    send_addr(24'h000050);
    spi_bits(8'h00, 3, r);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.Q !== 1'b0 || wel !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got Q=%b wel=%b expected 0 0", bus.Q, wel);
    end
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'hFF;
    wel_m = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.Q !== 1'b0) begin
      failures++;
      $display("FAIL midrst_q_after: got %b expected 0", bus.Q);
    end
    cs_high();
    wait_idle();
    do_read(24'h000050, 4);
    check_read("midrst_read", 24'h000050, 4);
    wren();
    rdsr(s);
    checks++;
    if (s !== {6'b0, wel_m, 1'b0}) begin
      failures++;
      $display("FAIL midrst_rdsr: got %h expected %h", s, {6'b0, wel_m, 1'b0});
    end
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_pp(24'h000050, 2);
    wait_idle();
    do_read(24'h000050, 2);
    check_read("midrst_pp_read", 24'h000050, 2);
  endtask

  initial begin
    test_reset();
    test_wren_pp();
    test_pp_no_wren();
    test_page_wrap();
    test_random();
    test_se();
    test_wren_partial();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
